// File: rtl/axi4s_frame_arbiter.sv
// axi4s_frame_arbiter: round-robin packet arbiter that merges NUM_TARGETS
// byte-wide AXI4-Stream sources onto one framing channel.
// Ports: aclk/aresetn (async active-low); target_tvalid/tready/tdata/tlast
// per-source slave side (source i data in [8i+7:8i]); initiator_* merged
// master side; grant_active high while a packet is owned; grant_idx is the
// current or most recent owner.
// Optional: define AXI4S_FRAME_ARBITER_ID_BYTE_EN to prefix every packet with
// a channel-ID byte (ID_BASE + grant_idx).
module axi4s_frame_arbiter #(
   parameter int unsigned NUM_TARGETS = 2,
   parameter logic [7:0]  ID_BASE     = 8'h80
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   input  logic [NUM_TARGETS-1:0]         target_tvalid,
   output logic [NUM_TARGETS-1:0]         target_tready,
   input  logic [8*NUM_TARGETS-1:0]       target_tdata,
   input  logic [NUM_TARGETS-1:0]         target_tlast,
   output logic                           initiator_tvalid,
   input  logic                           initiator_tready,
   output logic [7:0]                     initiator_tdata,
   output logic                           initiator_tlast,
   output logic                           grant_active,
   output logic [$clog2(NUM_TARGETS)-1:0] grant_idx
);

   localparam int unsigned GW = $clog2(NUM_TARGETS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ID   = 2'd1,
      S_PASS = 2'd2
   } state_e;

   state_e                              state_q, state_d;
   logic [GW-1:0]                       grant_q, grant_d;
   logic [GW-1:0]                       win;
   logic [GW-1:0]                       idx;
   logic                                req_any;
   logic [NUM_TARGETS-1:0][7:0]         tdata_a;
   logic                                own_valid;
   logic                                own_last;
   logic [7:0]                          own_data;

   assign tdata_a   = target_tdata;
   assign own_valid = target_tvalid[grant_q];
   assign own_last  = target_tlast[grant_q];
   assign own_data  = tdata_a[grant_q];

`ifndef AXI4S_FRAME_ARBITER_ID_BYTE_EN
   logic unused_id_base;
   assign unused_id_base = ^ID_BASE;
`endif

   // Scan from the farthest candidate down to the nearest so the last hit
   // is the first requester after the previous owner. Explicit modulo since
   // NUM_TARGETS need not be a power of two.
   always_comb begin
      win     = grant_q;
      idx     = '0;
      req_any = 1'b0;
      for (int k = NUM_TARGETS; k >= 1; k--) begin
         idx = GW'((int'(grant_q) + k) % NUM_TARGETS);
         if (target_tvalid[idx]) begin
            win     = idx;
            req_any = 1'b1;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
         grant_q <= GW'(NUM_TARGETS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_any) begin
               grant_d = win;
`ifdef AXI4S_FRAME_ARBITER_ID_BYTE_EN
               state_d = S_ID;
`else
               state_d = S_PASS;
`endif
            end
         end
`ifdef AXI4S_FRAME_ARBITER_ID_BYTE_EN
         S_ID: begin
            if (initiator_tready) state_d = S_PASS;
         end
`endif
         S_PASS: begin
            // Release only on the tlast handshake; the IDLE cycle that
            // follows is the arbitration bubble.
            if (own_valid && initiator_tready && own_last)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      initiator_tvalid = 1'b0;
      initiator_tdata  = 8'h00;
      initiator_tlast  = 1'b0;
      target_tready    = '0;
      unique case (state_q)
         S_PASS: begin
            initiator_tvalid       = own_valid;
            initiator_tdata        = own_data;
            initiator_tlast        = own_last;
            target_tready[grant_q] = initiator_tready;
         end
`ifdef AXI4S_FRAME_ARBITER_ID_BYTE_EN
         S_ID: begin
            initiator_tvalid = 1'b1;
            initiator_tdata  = ID_BASE + {{(8-GW){1'b0}}, grant_q};
         end
`endif
         default: begin
         end
      endcase
   end

   assign grant_active = (state_q != S_IDLE);
   assign grant_idx    = grant_q;

endmodule

// File: tb/tb_axi4s_frame_arbiter.sv
// tb_axi4s_frame_arbiter: scenario tasks with a packet-level scoreboard
// (per-source byte queues plus a round-robin owner model).
module tb_axi4s_frame_arbiter;

   localparam int N  = 3;
   localparam int GW = $clog2(N);
   localparam logic [7:0] IDB = 8'h80;
`ifdef AXI4S_FRAME_ARBITER_ID_BYTE_EN
   localparam int IDN = 1;
`else
   localparam int IDN = 0;
`endif

   logic          aclk;
   logic          aresetn;
   logic [N-1:0]  tv;
   logic [N-1:0]  trdy;
   logic [8*N-1:0] td;
   logic [N-1:0]  tl;
   logic          itv;
   logic          ir;
   logic [7:0]    itd;
   logic          itl;
   logic          ga;
   logic [GW-1:0] gi;

   axi4s_frame_arbiter #(
      .NUM_TARGETS(N),
      .ID_BASE    (IDB)
   ) dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .target_tvalid   (tv),
      .target_tready   (trdy),
      .target_tdata    (td),
      .target_tlast    (tl),
      .initiator_tvalid(itv),
      .initiator_tready(ir),
      .initiator_tdata (itd),
      .initiator_tlast (itl),
      .grant_active    (ga),
      .grant_idx       (gi)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int checks = 0;
   int errs   = 0;

   logic [8:0] drv_q [N][$];
   logic [8:0] exp_q [N][$];
   logic [8:0] out_log [$];
   int         grant_log [$];
   bit         shown [N];
   int         gap_pct;
   int         rdy_mode;
   bit         rdy_pat [$];
   int         run_cyc;

   int         m_last;
   int         m_owner;
   bit         m_id;
   bit         prev_ga;
   bit         prev_last;
   logic [N-1:0] prev_req;

   function automatic int rr(input int last, input logic [N-1:0] req);
      for (int k = 1; k <= N; k++) begin
         if (req[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         drv_q[i].delete();
         exp_q[i].delete();
         shown[i] = 1'b0;
      end
      m_last    = N - 1;
      m_owner   = -1;
      m_id      = 1'b0;
      prev_ga   = 1'b0;
      prev_last = 1'b0;
      prev_req  = '0;
   endtask

   task automatic do_reset();
      @(negedge aclk);
      aresetn = 1'b0;
      tv = '0;
      tl = '0;
      td = '0;
      ir = 1'b0;
      clear_model();
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
   endtask

   task automatic add_byte(input int s, input logic [7:0] d, input bit last);
      drv_q[s].push_back({last, d});
      exp_q[s].push_back({last, d});
   endtask

   task automatic add_pkt(input int s, input int len);
      for (int b = 0; b < len; b++)
         add_byte(s, 8'($urandom), b == len - 1);
   endtask

   // Drives all sources from their queues and checks the merged stream
   // against the scoreboard every cycle until traffic drains.
   task automatic run_traffic(input string tag, input int maxc,
                              input int stop_hs);
      int hs;
      int w;
      bit done;
      bit any;
      bit last_now;
      logic [8:0] e;
      logic [N-1:0] oh;
      hs = 0;
      done = 1'b0;
      run_cyc = 0;
      while (!done && run_cyc < maxc) begin
         @(negedge aclk);
         run_cyc++;
         for (int i = 0; i < N; i++) begin
            if (!shown[i] && drv_q[i].size() > 0 &&
                $urandom_range(99) >= gap_pct)
               shown[i] = 1'b1;
            tv[i]        = shown[i];
            tl[i]        = shown[i] ? drv_q[i][0][8] : 1'b0;
            td[8*i +: 8] = shown[i] ? drv_q[i][0][7:0] : 8'h00;
         end
         case (rdy_mode)
            0:       ir = ($urandom_range(3) != 0);
            1:       ir = 1'b1;
            default: ir = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
         endcase
         #1;
         last_now = 1'b0;
         if (prev_last) begin
            checks++;
            if (ga !== 1'b0 || itv !== 1'b0) begin
               errs++;
               $display("FAIL %s bubble: ga=%b itv=%b want 0 0", tag, ga, itv);
            end
            m_owner = -1;
         end
         if (!prev_ga) begin
            checks++;
            if (ga !== (prev_req != '0)) begin
               errs++;
               $display("FAIL %s arb_latency: ga=%b req=%b", tag, ga, prev_req);
            end
            if (ga === 1'b1) begin
               w = rr(m_last, prev_req);
               checks++;
               if (gi !== w[GW-1:0] || w < 0) begin
                  errs++;
                  $display("FAIL %s grant: got %0d want %0d", tag, gi, w);
               end
               m_owner = w;
               m_last  = (w < 0) ? m_last : w;
               m_id    = (IDN != 0);
               grant_log.push_back(w);
            end
         end
         checks++;
         if (gi !== m_last[GW-1:0]) begin
            errs++;
            $display("FAIL %s grant_idx: got %0d want %0d", tag, gi, m_last);
         end
         if (m_owner >= 0) begin
            oh = N'(1) << m_owner;
            if (m_id) begin
               checks++;
               if (itv !== 1'b1 || itd !== IDB + 8'(m_owner) ||
                   itl !== 1'b0 || trdy !== '0) begin
                  errs++;
                  $display("FAIL %s id_byte: v=%b d=%h l=%b rdy=%b want 1 %h 0 0",
                           tag, itv, itd, itl, trdy, IDB + 8'(m_owner));
               end
               if (ir) begin
                  out_log.push_back({1'b0, itd});
                  m_id = 1'b0;
                  hs++;
               end
            end else begin
               checks++;
               if (itv !== tv[m_owner] || trdy !== (ir ? oh : '0)) begin
                  errs++;
                  $display("FAIL %s pass_ctrl: itv=%b rdy=%b want %b %b",
                           tag, itv, trdy, tv[m_owner], ir ? oh : '0);
               end
               if (itv === 1'b1 && ir) begin
                  e = (exp_q[m_owner].size() > 0) ?
                      exp_q[m_owner].pop_front() : 9'h1ff;
                  checks++;
                  if ({itl, itd} !== e) begin
                     errs++;
                     $display("FAIL %s data: got %b/%h want %b/%h",
                              tag, itl, itd, e[8], e[7:0]);
                  end
                  out_log.push_back({itl, itd});
                  last_now = (itl === 1'b1);
                  hs++;
               end
            end
         end else begin
            checks++;
            if (itv !== 1'b0 || trdy !== '0) begin
               errs++;
               $display("FAIL %s idle_out: itv=%b rdy=%b want 0 0", tag, itv, trdy);
            end
         end
         for (int i = 0; i < N; i++) begin
            if (tv[i] && trdy[i] === 1'b1) begin
               void'(drv_q[i].pop_front());
               shown[i] = 1'b0;
            end
         end
         prev_ga   = (ga === 1'b1);
         prev_req  = tv;
         prev_last = last_now;
         any = 1'b0;
         for (int i = 0; i < N; i++)
            if (drv_q[i].size() > 0 || shown[i]) any = 1'b1;
         if (stop_hs > 0) done = (hs >= stop_hs);
         else done = !any && m_owner < 0 && !prev_last;
      end
      if (!done) begin
         checks++;
         errs++;
         $display("FAIL %s timeout: %0d cycles used, limit %0d", tag, run_cyc, maxc);
      end
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      tv = '0;
      tl = '0;
      td = '0;
      ir = 1'b0;
      clear_model();
      repeat (3) @(negedge aclk);
      #1;
      checks++;
      if (itv !== 1'b0 || trdy !== '0 || itd !== 8'h00 || itl !== 1'b0 ||
          ga !== 1'b0 || gi !== GW'(N - 1)) begin
         errs++;
         $display("FAIL reset_vals: itv=%b rdy=%b d=%h l=%b ga=%b gi=%0d want 0 0 00 0 0 %0d",
                  itv, trdy, itd, itl, ga, gi, N - 1);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge aclk);
         ir = 1'(($urandom));
         #1;
         checks++;
         if (itv !== 1'b0 || ga !== 1'b0 || trdy !== '0 || gi !== GW'(N - 1)) begin
            errs++;
            $display("FAIL idle_%0d: itv=%b ga=%b rdy=%b gi=%0d want 0 0 0 %0d",
                     c, itv, ga, trdy, gi, N - 1);
         end
      end
   endtask

   task automatic test_single();
      gap_pct  = 0;
      rdy_mode = 1;
      out_log.delete();
      grant_log.delete();
      add_byte(1, 8'h11, 1'b0);
      add_byte(1, 8'h22, 1'b0);
      add_byte(1, 8'h33, 1'b1);
      run_traffic("single", 50, 0);
      checks++;
      if (grant_log.size() != 1 || grant_log[0] != 1) begin
         errs++;
         $display("FAIL single_grant: got %p want '{1}", grant_log);
      end
      checks++;
      if (out_log.size() != 3 + IDN || out_log[out_log.size()-1] !== 9'h133) begin
         errs++;
         $display("FAIL single_bytes: got %p want %0d bytes ending 133",
                  out_log, 3 + IDN);
      end
      checks++;
      if (run_cyc != 5 + IDN) begin
         errs++;
         $display("FAIL single_cycles: got %0d want %0d", run_cyc, 5 + IDN);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      gap_pct  = 0;
      rdy_mode = 1;
      grant_log.delete();
      for (int p = 0; p < 2; p++)
         for (int s = 0; s < N; s++)
            add_pkt(s, 2);
      run_traffic("rr", 200, 0);
      checks++;
      if (grant_log.size() != 6) begin
         errs++;
         $display("FAIL rr_count: got %0d want 6", grant_log.size());
      end
      for (int k = 0; k < grant_log.size() && k < 6; k++) begin
         checks++;
         if (grant_log[k] != k % N) begin
            errs++;
            $display("FAIL rr_order_%0d: got %0d want %0d", k, grant_log[k], k % N);
         end
      end
      checks++;
      if (run_cyc != 1 + 6 * (3 + IDN)) begin
         errs++;
         $display("FAIL rr_cycles: got %0d want %0d", run_cyc, 1 + 6 * (3 + IDN));
      end
   endtask

   task automatic test_backpressure();
      gap_pct  = 0;
      rdy_mode = 2;
      rdy_pat  = '{1, 0, 0, 1, 0, 1};
      out_log.delete();
      grant_log.delete();
      add_byte(0, 8'hAA, 1'b0);
      add_byte(0, 8'hBB, 1'b0);
      add_byte(0, 8'hCC, 1'b1);
      run_traffic("bp", 50, 0);
      checks++;
      if (grant_log.size() != 1 || grant_log[0] != 0) begin
         errs++;
         $display("FAIL bp_grant: got %p want '{0}", grant_log);
      end
      checks++;
      if (out_log.size() != 3 + IDN || out_log[IDN] !== 9'h0AA ||
          out_log[IDN+1] !== 9'h0BB || out_log[IDN+2] !== 9'h1CC) begin
         errs++;
         $display("FAIL bp_bytes: got %p want AA BB CC(last)", out_log);
      end
   endtask

   task automatic test_reset_mid();
      gap_pct  = 0;
      rdy_mode = 1;
      for (int b = 0; b < 5; b++) add_byte(1, 8'(8'h40 + b), b == 4);
      run_traffic("rmid", 50, 2 + IDN);
      @(negedge aclk);
      aresetn = 1'b0;
      #1;
      checks++;
      if (itv !== 1'b0 || trdy !== '0 || itd !== 8'h00 || itl !== 1'b0 ||
          ga !== 1'b0 || gi !== GW'(N - 1)) begin
         errs++;
         $display("FAIL rmid_zero: itv=%b rdy=%b d=%h l=%b ga=%b gi=%0d",
                  itv, trdy, itd, itl, ga, gi);
      end
      tv = '0;
      tl = '0;
      td = '0;
      clear_model();
      @(negedge aclk);
      aresetn = 1'b1;
      grant_log.delete();
      add_pkt(0, 2);
      add_pkt(1, 2);
      run_traffic("rmid_after", 50, 0);
      checks++;
      if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
         errs++;
         $display("FAIL rmid_order: got %p want '{0,1}", grant_log);
      end
   endtask

   task automatic test_random();
      gap_pct  = 25;
      rdy_mode = 0;
      for (int p = 0; p < 40; p++)
         add_pkt($urandom_range(N - 1), $urandom_range(5, 1));
      run_traffic("random", 4000, 0);
      for (int s = 0; s < N; s++) begin
         checks++;
         if (exp_q[s].size() != 0) begin
            errs++;
            $display("FAIL random_drain_%0d: %0d bytes left want 0", s, exp_q[s].size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", checks - errs, checks);
      $finish;
   end

endmodule
